// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared state encoding and constants for the instruction memory responder
package rv_mem_pkg;

  typedef enum logic [2:0] {
    s_IDLE = 3'b001,
    s_WAIT = 3'b010,
    s_RESP = 3'b100
  } state_e;

  localparam logic [31:0] OOR_NOP   = 32'h0000_0013;
  localparam logic [7:0]  LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci LFSR: feedback from bits 7,5,4,3
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Fibonacci LFSR used to inject pseudo-random fetch stalls
module lfsr8
  import rv_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  assign q_d = {q_q[6:0], ^(q_q & LFSR_TAPS)};

  always_ff @(posedge clk) begin
    if (rst) q_q <= LFSR_SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - single-outstanding instruction memory responder with fixed latency
// INST_STALL_INJ_EN adds LFSR-driven request back-pressure and wait extension.
module inst_mem_responder
  import rv_mem_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter int          LATENCY  = 2,
  parameter logic [31:0] OOR_WORD = OOR_NOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PC,
  input  logic              Inst_Req_Valid,
  output logic              Inst_Req_Ready,
  output logic [31:0]       Instruction,
  output logic              Inst_Valid,
  input  logic              Inst_Ready,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic [31:0]       resp_cnt
);

  localparam int          CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               oor_q, oor_d;
  logic               valid_q, valid_d;
  logic [31:0]        data_q;
  logic [31:0]        resp_cnt_q, resp_cnt_d;
  logic               capture;
  logic               req_ok;
  logic               wait_go;

  logic [31:0] mem [0:(2**ADDR_W)-1];

`ifdef INST_STALL_INJ_EN
  logic [7:0] lfsr;
  logic       unused_lfsr;

  lfsr8 u_lfsr8 (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign req_ok      = lfsr[0];
  assign wait_go     = lfsr[1];
  assign unused_lfsr = ^lfsr[7:2];
`else
  assign req_ok  = 1'b1;
  assign wait_go = 1'b1;
`endif

  logic unused_pc;
  assign unused_pc = ^PC[1:0];

  assign Inst_Req_Ready = (state_q == s_IDLE) && req_ok;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    oor_d      = oor_q;
    resp_cnt_d = resp_cnt_q;
    capture    = 1'b0;
    case (state_q)
      s_IDLE: begin
        if (Inst_Req_Valid && Inst_Req_Ready) begin
          state_d = s_WAIT;
          idx_d   = PC[ADDR_W+1:2];
          oor_d   = |PC[31:ADDR_W+2];
          cnt_d   = CNT_LOAD;
        end
      end
      s_WAIT: begin
        if (cnt_q == '0) begin
          if (wait_go) begin
            capture = 1'b1;
            state_d = s_RESP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      s_RESP: begin
        if (Inst_Ready) begin
          state_d    = s_IDLE;
          resp_cnt_d = resp_cnt_q + 32'd1;
        end
      end
      default: state_d = s_IDLE;
    endcase
    valid_d = (state_d == s_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= s_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      oor_q      <= 1'b0;
      valid_q    <= 1'b0;
      resp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      oor_q      <= oor_d;
      valid_q    <= valid_d;
      resp_cnt_q <= resp_cnt_d;
    end
  end

  // Preload port has no reset so the array stays a plain RAM.
  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
  end

  // Capture reads the pre-write contents when a preload hits the same word this cycle.
  always_ff @(posedge clk) begin
    if (rst)          data_q <= '0;
    else if (capture) data_q <= oor_q ? OOR_WORD : mem[idx_q];
  end

  assign Inst_Valid  = valid_q;
  assign Instruction = data_q;
  assign resp_cnt    = resp_cnt_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// tb/tb_inst_mem_responder.sv - self-checking bench for inst_mem_responder
module tb_inst_mem_responder;

  localparam int ADDR_W  = 10;
  localparam int LATENCY = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       PC = '0;
  logic              Inst_Req_Valid = 1'b0;
  logic              Inst_Req_Ready;
  logic [31:0]       Instruction;
  logic              Inst_Valid;
  logic              Inst_Ready = 1'b0;
  logic              ld_we = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [31:0]       ld_data = '0;
  logic [31:0]       resp_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  inst_mem_responder #(
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .PC             (PC),
    .Inst_Req_Valid (Inst_Req_Valid),
    .Inst_Req_Ready (Inst_Req_Ready),
    .Instruction    (Instruction),
    .Inst_Valid     (Inst_Valid),
    .Inst_Ready     (Inst_Ready),
    .ld_we          (ld_we),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .resp_cnt       (resp_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference memory contents as the loader left them.
  logic [31:0] shadow [int];

  function automatic logic [31:0] ref_word(logic [31:0] pc);
    if (pc >= (32'd4 << ADDR_W)) return 32'h0000_0013;
    return shadow[int'(pc >> 2)];
  endfunction

  // Transaction model: one request in flight, response visible LATENCY edges after accept.
  bit          m_busy = 1'b0;
  int          m_acc  = 0;
  int          cyc    = 0;
  logic [31:0] m_word = '0;
  logic [31:0] m_cnt  = '0;

  always @(negedge clk) begin
    bit m_valid;
    m_valid = m_busy && ((cyc - m_acc) >= LATENCY);
`ifdef INST_STALL_INJ_EN
    if (Inst_Valid) begin
      chk("m_valid_busy", {31'd0, m_busy}, 32'd1);
      chk("m_min_latency", {31'd0, m_valid}, 32'd1);
      chk("m_instr", Instruction, m_word);
    end
    if (!m_busy) chk("m_valid_idle", {31'd0, Inst_Valid}, 32'd0);
    if (Inst_Req_Ready) chk("m_ready_idle", {31'd0, m_busy}, 32'd0);
`else
    chk("m_valid", {31'd0, Inst_Valid}, {31'd0, m_valid});
    if (m_valid) chk("m_instr", Instruction, m_word);
    chk("m_req_ready", {31'd0, Inst_Req_Ready}, {31'd0, !m_busy});
`endif
    chk("m_resp_cnt", resp_cnt, m_cnt);
    if (rst) begin
      m_busy = 1'b0;
      m_cnt  = '0;
    end else if (!m_busy && Inst_Req_Valid && Inst_Req_Ready) begin
      m_busy = 1'b1;
      m_acc  = cyc + 1;
      m_word = ref_word(PC);
    end else if (m_busy && Inst_Valid && Inst_Ready) begin
      m_busy = 1'b0;
      m_cnt  = m_cnt + 32'd1;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int addr, input logic [31:0] data);
    ld_we   = 1'b1;
    ld_addr = ADDR_W'(addr);
    ld_data = data;
    shadow[addr] = data;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc);
    int n;
    n = 0;
    PC = pc;
    Inst_Req_Valid = 1'b1;
    while (!Inst_Req_Ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("accept_timeout", 32'd1, 32'd0);
    tick();
    Inst_Req_Valid = 1'b0;
  endtask

  task automatic collect(input int hold, output logic [31:0] word, output int lat);
    logic [31:0] held;
    lat = 0;
    while (!Inst_Valid && lat < 200) begin
      tick();
      lat++;
    end
    if (lat >= 200) chk("resp_timeout", 32'd1, 32'd0);
    for (int h = 0; h < hold; h++) begin
      held = Instruction;
      tick();
      chk("hold_valid", {31'd0, Inst_Valid}, 32'd1);
      chk("hold_instr", Instruction, held);
      chk("hold_req_ready", {31'd0, Inst_Req_Ready}, 32'd0);
    end
    word = Instruction;
    Inst_Ready = 1'b1;
    tick();
    Inst_Ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          lat;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_valid", {31'd0, Inst_Valid}, 32'd0);
    chk("rst_instr", Instruction, 32'd0);
    chk("rst_resp_cnt", resp_cnt, 32'd0);
    chk("rst_req_ready", {31'd0, Inst_Req_Ready}, 32'd1);

    preload(0, 32'hDEAD_BEEF);
    preload(4, 32'h0050_0093);
    preload(8, 32'h1111_2222);

    // Fetch at PC=0x10, then hold the response for five cycles
    issue(32'h0000_0010);
    collect(5, w, lat);
    chk("t1_instr", w, 32'h0050_0093);
`ifdef INST_STALL_INJ_EN
    chk("t1_latency_min", {31'd0, lat >= LATENCY}, 32'd1);
`else
    chk("t1_latency", lat, 32'd2);
`endif
    chk("t1_resp_cnt", resp_cnt, 32'd1);

    issue(32'h0000_1000);
    collect(0, w, lat);
    chk("t3_oor", w, 32'h0000_0013);

    issue(32'h0000_0013);
    collect(1, w, lat);
    chk("t4_misaligned", w, 32'h0050_0093);
    chk("t4_resp_cnt", resp_cnt, 32'd3);

`ifndef INST_STALL_INJ_EN
    // Preload hitting the same word on the capture edge must not be returned
    issue(32'h0000_0020);
    tick();
    ld_we   = 1'b1;
    ld_addr = ADDR_W'(8);
    ld_data = 32'h3333_4444;
    tick();
    ld_we = 1'b0;
    shadow[8] = 32'h3333_4444;
    chk("rbw_valid", {31'd0, Inst_Valid}, 32'd1);
    chk("rbw_old", Instruction, 32'h1111_2222);
    collect(0, w, lat);
    issue(32'h0000_0020);
    collect(0, w, lat);
    chk("rbw_new", w, 32'h3333_4444);
`endif

    // Reset while the request is still waiting
    issue(32'h0000_0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid", {31'd0, Inst_Valid}, 32'd0);
    chk("t5_req_ready", {31'd0, Inst_Req_Ready}, 32'd1);
    chk("t5_resp_cnt", resp_cnt, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_resp", {31'd0, Inst_Valid}, 32'd0);
    end

    for (int a = 0; a < 16; a++) preload(a, $urandom);
    do_reset();
    for (int i = 0; i < 100; i++) begin
      logic [31:0] pc;
      logic [31:0] exp;
      if (i % 10 == 9) pc = 32'h8000_0000 | 32'($urandom_range(0, 255));
      else             pc = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      exp = ref_word(pc);
      issue(pc);
      collect(i % 3, w, lat);
      chk("t6_data", w, exp);
    end
    chk("t6_resp_cnt", resp_cnt, 32'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
